// File: rtl/corrimiento_pkg.sv
// Shared definitions for the universal shift register and its helpers:
// manual mode codes, controller state encoding and burst directions.
package corrimiento_pkg;

  // Manual operation selected by the mode input while idle
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_DER   = 2'b01,
    MODE_IZQ   = 2'b10,
    MODE_CARGA = 2'b11
  } mode_t;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_DONE  = 2'b10
  } estado_t;

  // Burst direction as sampled from the dir input
  localparam logic DIR_DER = 1'b0;
  localparam logic DIR_IZQ = 1'b1;

endpackage

// File: rtl/registro_corrimiento_universal_contador_bits.sv
// Counts completed shifts in a burst. Clear and enable are synchronous;
// tc flags that the count has reached N, tc_prox flags that the next
// enabled increment will reach it (lets the caller change state on the
// same edge as the last increment).
module contador_bits #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q,
  output logic          tc,
  output logic          tc_prox
);

  // Counter register: reset and clear both return to zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + CW'(1);
    end
  end

  assign tc      = (q == CW'(N));
  assign tc_prox = (q == CW'(N - 1));

endmodule

// File: rtl/registro_corrimiento_universal.sv
// Universal N-bit shift register: manual hold / shift right / shift left /
// parallel load while idle, plus an automatic N-shift burst with busy and
// a one-cycle done pulse. Two-process style: one combinational block works
// out next state and next data, one registered block commits them.
module registro_corrimiento_universal
  import corrimiento_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          h,
  input  logic [1:0]    mode,
  input  logic          dir,
  input  logic          start,
  input  logic          D,
  input  logic          DL,
  input  logic [N-1:0]  P,
  output logic [N-1:0]  R,
  output logic          so_r,
  output logic          so_l,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt
);

  estado_t        state, state_n;
  logic [N-1:0]   r_n;
  logic           dir_q, dir_n;
  logic           busy_n, done_n;
  logic           cnt_clr, cnt_en;
  logic           cnt_tc, cnt_tc_prox;

  // Serial bit D enters at the MSB, R[0] falls off
  function automatic logic [N-1:0] desp_der(input logic [N-1:0] r, input logic s);
    return {s, r[N-1:1]};
  endfunction

  // Serial bit DL enters at the LSB, R[N-1] falls off
  function automatic logic [N-1:0] desp_izq(input logic [N-1:0] r, input logic s);
    return {r[N-2:0], s};
  endfunction

  contador_bits #(
    .N  (N),
    .CW (CW)
  ) u_contador (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .q       (cnt),
    .tc      (cnt_tc),
    .tc_prox (cnt_tc_prox)
  );

  // Next state, next register contents and counter control
  always_comb begin
    state_n = state;
    r_n     = R;
    dir_n   = dir_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        // start wins over mode and does not need the enable
        if (start) begin
          dir_n   = dir;
          cnt_clr = 1'b1;
          state_n = ST_BURST;
        end else if (h) begin
          case (mode)
            MODE_DER:   r_n = desp_der(R, D);
            MODE_IZQ:   r_n = desp_izq(R, DL);
            MODE_CARGA: r_n = P;
            default:    r_n = R;
          endcase
        end
      end
      ST_BURST: begin
        // A full count should never be seen here; the guard keeps a
        // corrupted count from shifting past N
        if (h && !cnt_tc) begin
          r_n    = (dir_q == DIR_IZQ) ? desp_izq(R, DL) : desp_der(R, D);
          cnt_en = 1'b1;
          if (cnt_tc_prox) begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    busy_n = (state_n == ST_BURST);
    done_n = (state_n == ST_DONE);
  end

  // Commit state, data and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      R     <= '0;
      dir_q <= DIR_DER;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      R     <= r_n;
      dir_q <= dir_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  assign so_r = R[0];
  assign so_l = R[N-1];

endmodule

// File: tb/tb_registro_corrimiento_universal.sv
// Directed bench for the universal shift register. A behavioural model
// (plain shift arithmetic plus a phase number) is compared against every
// output on each falling edge; literal expectations pin key results.
module tb_registro_corrimiento_universal;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst, h, start, D, DL, dir;
  logic [1:0]    mode;
  logic [N-1:0]  P, R;
  logic          so_r, so_l, busy, done;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  registro_corrimiento_universal #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .h     (h),
    .mode  (mode),
    .dir   (dir),
    .start (start),
    .D     (D),
    .DL    (DL),
    .P     (P),
    .R     (R),
    .so_r  (so_r),
    .so_l  (so_l),
    .busy  (busy),
    .done  (done),
    .cnt   (cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: ph 0 = idle, 1 = burst, 2 = done
  typedef struct {
    logic [N-1:0] r;
    int           cnt;
    int           ph;
    logic         d;
  } model_t;

  model_t m;

  function automatic model_t next_model(input model_t c, input logic i_rst, input logic i_h,
                                        input logic [1:0] i_mode, input logic i_dir,
                                        input logic i_start, input logic i_d, input logic i_dl,
                                        input logic [N-1:0] i_p);
    model_t n;
    logic [N-1:0] rr, rl;
    n  = c;
    rr = (c.r >> 1) | (N'(i_d) << (N - 1));
    rl = (c.r << 1) | N'(i_dl);
    if (i_rst) begin
      n.r = '0; n.cnt = 0; n.ph = 0; n.d = 1'b0;
    end else if (c.ph == 0) begin
      if (i_start) begin
        n.d = i_dir; n.cnt = 0; n.ph = 1;
      end else if (i_h) begin
        if (i_mode == 2'd1) n.r = rr;
        else if (i_mode == 2'd2) n.r = rl;
        else if (i_mode == 2'd3) n.r = i_p;
      end
    end else if (c.ph == 1) begin
      if (i_h) begin
        n.r   = c.d ? rl : rr;
        n.cnt = c.cnt + 1;
        if (n.cnt == N) n.ph = 2;
      end
    end else begin
      n.ph = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= next_model(m, rst, h, mode, dir, start, D, DL, P);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_R", R, m.r);
      chk("model_so_r", so_r, m.r[0]);
      chk("model_so_l", so_l, m.r[N-1]);
      chk("model_busy", busy, m.ph == 1);
      chk("model_done", done, m.ph == 2);
      chk("model_cnt", cnt, m.cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs ncyc cycles; h for the edge after sample i is hmask[i]
  task automatic run_burst(input logic [15:0] hmask, input int ncyc, input bit clr_on_done,
                           output int nbusy, output int ndone, output logic [15:0] seq);
    nbusy = 0;
    ndone = 0;
    seq   = '0;
    for (int i = 0; i < ncyc; i++) begin
      if (busy === 1'b1) begin
        nbusy++;
        seq = {seq[14:0], so_r};
      end
      if (done === 1'b1) begin
        ndone++;
        if (clr_on_done) begin
          start = 1'b0;
          mode  = 2'd0;
        end
      end
      h = hmask[i];
      tick();
    end
  endtask

  int          nb, nd;
  logic [15:0] sq;

  initial begin
    rst = 1'b1; h = 1'b0; start = 1'b0; D = 1'b0; DL = 1'b0; dir = 1'b0;
    mode = 2'd0; P = '0;
    tick();
    tick();
    chk("rst_R", R, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", cnt, 0);
    rst    = 1'b0;
    chk_on = 1'b1;

    // Manual ops
    mode = 2'd3; P = 8'hA5; h = 1'b1; tick();
    chk("load_A5", R, 8'hA5);
    mode = 2'd1; D = 1'b1; tick();
    chk("shr_D2", R, 8'hD2);
    mode = 2'd2; DL = 1'b0; tick();
    chk("shl_A4", R, 8'hA4);
    h = 1'b0; mode = 2'd1; tick();
    chk("hold_h0", R, 8'hA4);

    // Right burst from 81
    h = 1'b1; mode = 2'd3; P = 8'h81; tick();
    mode = 2'd0;
    start = 1'b1; dir = 1'b0; D = 1'b0; tick();
    start = 1'b0;
    run_burst(16'hFFFF, 12, 1'b0, nb, nd, sq);
    chk("rb_busy_cycles", nb, 8);
    chk("rb_so_r_seq", sq[7:0], 8'h81);
    chk("rb_done_pulses", nd, 1);
    chk("rb_R", R, 8'h00);
    chk("rb_cnt", cnt, 8);

    // Left burst with three stalls
    h = 1'b1; mode = 2'd3; P = 8'h01; tick();
    mode = 2'd0;
    start = 1'b1; dir = 1'b1; DL = 1'b1; tick();
    start = 1'b0; dir = 1'b0;
    run_burst(16'hFF9B, 14, 1'b0, nb, nd, sq);
    chk("lb_busy_cycles", nb, 11);
    chk("lb_done_pulses", nd, 1);
    chk("lb_R", R, 8'hFF);
    chk("lb_cnt", cnt, 8);

    // start / load / dir asserted throughout the burst and DONE
    h = 1'b1; mode = 2'd3; P = 8'h3C; tick();
    chk("ig_load_3C", R, 8'h3C);
    start = 1'b1; dir = 1'b0; D = 1'b1; mode = 2'd3; P = 8'h5A; tick();
    chk("ig_start_no_load", R, 8'h3C);
    dir = 1'b1;
    run_burst(16'hFFFF, 12, 1'b1, nb, nd, sq);
    chk("ig_busy_cycles", nb, 8);
    chk("ig_done_pulses", nd, 1);
    chk("ig_R", R, 8'hFF);
    chk("ig_busy_after", busy, 1'b0);

    // Abort mid-burst
    h = 1'b1; mode = 2'd3; P = 8'h81; tick();
    mode = 2'd0;
    start = 1'b1; dir = 1'b0; D = 1'b0; tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ab_cnt4", cnt, 4);
    chk("ab_R_mid", R, 8'h08);
    rst = 1'b1; tick();
    chk("ab_R", R, 8'h00);
    chk("ab_busy", busy, 1'b0);
    chk("ab_cnt", cnt, 0);
    chk("ab_done", done, 1'b0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk("ab_no_done", nd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/registro_corrimiento_universal.md
# registro_corrimiento_universal

Parametrised universal shift register, the successor to the team's fixed right-shift register. It adds right shift, left shift, parallel load and hold under a mode input. It also runs an automatic N-bit burst with busy/done handshake, so a serialiser or deserialiser can hand it a word and wait for completion. It sits between the parallel datapath and single-bit serial links in the FPGA design.

## Interface
- `N`, default 8: register width in bits; N ≥ 2.
- `CW`, default $clog2(N+1): burst counter width; derived, not overridden.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `h`  in  1  enable; no register change when 0, in both IDLE and BURST.
- `mode`  in  2  manual op in IDLE: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `dir`  in  1  burst direction, sampled with `start`: 0 right, 1 left.
- `start`  in  1  launches an N-shift burst; honoured only in IDLE.
- `D`  in  1  serial input for right shifts; enters at bit N-1.
- `DL`  in  1  serial input for left shifts; enters at bit 0.
- `P`  in  N  parallel load value.
- `R`  out  N  register contents (registered).
- `so_r`  out  1  R[0]: the bit lost on the next right shift.
- `so_l`  out  1  R[N-1]: the bit lost on the next left shift.
- `busy`  out  1  high while in BURST.
- `done`  out  1  one-cycle pulse after the Nth burst shift.
- `cnt`  out  CW  shifts completed in the current or last burst.

## Operation
- **States:** IDLE, BURST, DONE.
- **IDLE:**
  - `start`=1 → latch `dir`, set `cnt`=0, go to BURST, `R` unchanged. `start` has priority over `mode`, and does not need `h`.
  - Otherwise, if `h`=1, apply `mode`:
    - right: R ← {D, R[N-1:1]}
    - left: R ← {R[N-2:0], DL}
    - load: R ← P
    - hold: R unchanged.
- **BURST:**
  - Each cycle with `h`=1: shift once in the latched direction, `cnt` ← `cnt`+1.
  - `h`=0 stalls the shift and `cnt`.
  - `mode`, `dir`, `start` and `P` are ignored.
  - On the shift that makes `cnt`=N, go to DONE.
- **DONE:** `done`=1 and `busy`=0 for one cycle; `R` and `cnt` hold; all inputs ignored; then IDLE.
- `cnt` holds its final value N in IDLE until the next `start`.
- **Reset mid-burst:** aborts; everything returns to reset values on that edge.

## Timing
- **Reset values:** R=0, cnt=0, busy=0, done=0, state IDLE; so_r=so_l=0 follow from R.
- **Manual ops:** result visible in `R` one cycle after the edge that samples the inputs.
- **Burst latency:** `start` edge plus N enabled shift cycles; `done` rises on the edge of the Nth shift and lasts one cycle. Minimum `start`→`done` is N+1 edges.
- `busy` rises on the edge that samples `start` and falls on the edge that sets `done`.
- `start` held high through DONE is ignored there. If still high in IDLE, it launches a new burst.
- `so_r` and `so_l` are combinational from `R` and glitch-free, since they come from flops.

## Structure
- **Shared package `corrimiento_pkg`:**
  - mode constants MODE_HOLD, MODE_DER, MODE_IZQ, MODE_CARGA;
  - state encoding ST_IDLE, ST_BURST, ST_DONE;
  - direction constants DIR_DER=0, DIR_IZQ=1.
- **Sub-module `contador_bits`:** parametrised CW-bit counter with clear, enable and terminal-count (==N) output. It is reused by the team's serial receivers.
- **Top-level body:** next-state/next-data combinational block plus one registered block, in the two-process style already used for the team's registers.

## Test plan
- **Reset and load:** rst=1 for 2 cycles → R=0, busy=0, done=0. Then mode=11, P=8'hA5, h=1 → R=8'hA5 next cycle.
- **Manual shifts:** from 8'hA5, mode=01, D=1 → 8'hD2. Then mode=10, DL=0 → 8'hA4. With h=0 → R holds.
- **Right burst:** R=8'h81, start=1, dir=0, D=0 → busy for 8 cycles and so_r sequence 1,0,0,0,0,0,0,1. done pulses exactly once, R=8'h00, cnt=8.
- **Stalled left burst:** R=8'h01, dir=1, DL=1, h low on 3 burst cycles → done after 11 BURST cycles, R=8'hFF.
- **Ignored inputs:** start and mode=11 asserted during BURST and DONE → no load and no restart. Burst result and single done pulse are unaffected.
- **Abort:** rst=1 at cnt=4 mid-burst → next cycle R=0, busy=0, cnt=0, and no done pulse.
